mul_div_unit_16: RTL and testbench
==================================

// Module: mul_div_unit_16
// PURPOSE
//  Iterative 16-bit multiply/divide unit in the execute stage of the 16-bit core.
//  It takes operands from the register-read stage and runs a start/busy/done handshake.
//  result_lo_out feeds input d2 of the 3:1 writeback mux, with the ALU result on d0 and memory data on d1.
//  result_hi_out feeds the HI special register.
//  Shift-add multiply and restoring divide; one result bit per cycle; signed ops use magnitudes with a final sign fix.
// PARAMETERS
//  WIDTH  16  operand/result width; the core uses only 16; the counter width is $clog2(WIDTH)
// PORTS
//  clk            in   1      core clock, all state on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  start_in       in   1      request; accepted only when busy_out==0
//  op_in          in   2      md_op_t: MUL_U=00, MUL_S=01, DIV_U=10, DIV_S=11
//  a_in           in   16     multiplicand / dividend
//  b_in           in   16     multiplier / divisor
//  flush_in       in   1      synchronous abort from hazard/branch unit
//  busy_out       out  1      operation in flight
//  done_out       out  1      one-cycle pulse: results valid
//  result_lo_out  out  16     product[15:0] / quotient
//  result_hi_out  out  16     product[31:16] / remainder
//  div0_out       out  1      last divide had a zero divisor; valid with done, held after it
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. busy_out, done_out and div0_out are 0. result_lo_out and result_hi_out are 0x0000.
//  FSM states: IDLE, CALC, FIX, DONE.
//  - IDLE/DONE -> CALC when start_in accepted at edge T0.
//    Operands and op are latched, negative signed operands are converted to magnitudes, and cnt=0.
//  - CALC: one iteration per edge. cnt reaches 15 on the 16th iteration (edge T16), then -> FIX.
//  - FIX (edge T17): apply sign rules, register the outputs, -> DONE.
//  - DONE: done_out=1 for exactly this cycle. Next edge -> IDLE, or -> CALC on a new accepted start.
//  busy_out=1 in CALC and FIX only. Accept rule: start_in && !busy_out. start_in while busy is ignored.
//  Latency: the done pulse is in the cycle after edge T17 (18 cycles start-to-done).
//  Outputs are held unchanged from DONE until the FIX of the next operation.
//  Multiply: unsigned 16x16 gives a 32-bit product.
//  - MUL_S negates the 32-bit product when sign(a)^sign(b).
//  - -32768*-32768 = 0x4000_0000.
//  Divide: restoring, with a 17-bit partial remainder.
//  - DIV_S quotient sign = sign(a)^sign(b). Remainder sign = sign(a), truncating toward zero.
//  - -32768 / -1: quotient 0x8000, remainder 0x0000 (wraps, no flag).
//  Divide by zero: detected at accept.
//  - Goes CALC-free: IDLE -> FIX -> DONE, with done in the cycle after T1.
//  - lo=0xFFFF, hi=a_in (unmodified), div0_out=1. Multiplies and non-zero divides clear div0_out at FIX.
//  flush_in=1 at any edge forces IDLE and drops busy_out. No done_out is produced; outputs keep their old values.
//  - flush_in has priority over start_in in the same cycle, so the start is lost.
//  rst_n asserted mid-operation clears everything immediately. No done_out follows release.
// STRUCTURE
//  mycpu_pkg gets:
//  - typedef enum logic [1:0] md_op_t {MD_MUL_U, MD_MUL_S, MD_DIV_U, MD_DIV_S}
//  - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_CALC, MD_FIX, MD_DONE}
//  - localparam MD_ITER = 16
//  Single module, no sub-module.
//  - One shared 17-bit adder/subtractor is muxed between the add step (MUL) and the trial subtract (DIV).
//  - A 32-bit acc/quotient shift register and a 4-bit iteration counter.
// TESTING
//  1. Reset during CALC (cycle 8): busy/done/div0 = 0 and results = 0 immediately. Idle until the next start.
//  2. MUL_U a=0xFFFF b=0xFFFF: done in the cycle after T17, lo=0x0001, hi=0xFFFE, div0=0, busy high T0..T17.
//  3. MUL_S a=0xFFFD(-3) b=0x0007: lo=0xFFEB, hi=0xFFFF. Then DIV_S a=0xFFF9(-7) b=0x0002: lo=0xFFFD, hi=0xFFFF.
//  4. DIV_U a=0x1234 b=0x0000: done in the cycle after T1, lo=0xFFFF, hi=0x1234, div0=1.
//     Next MUL_U 2*3 clears div0 and gives lo=0x0006.
//  5. DIV_U 100/7 started, flush_in at cycle 5, start_in re-raised the same cycle:
//     - no done, outputs unchanged, busy=0 the next cycle.
//     - A start in the following cycle gives lo=0x000E, hi=0x0002.
//  6. Back-to-back: start held high through DONE of DIV_S 0x8000/0xFFFF (lo=0x8000, hi=0).
//     The second op is accepted in the DONE cycle, the start during busy is ignored, and exactly 2 done pulses occur.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mycpu_pkg;

  typedef enum logic [1:0] {
    MD_MUL_U = 2'b00,
    MD_MUL_S = 2'b01,
    MD_DIV_U = 2'b10,
    MD_DIV_S = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  localparam int MD_ITER = 16;

endpackage

// File: rtl/mul_div_unit_16.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, signed ops computed on magnitudes with a final
// sign fix. lo feeds the writeback mux, hi feeds the HI special register.
module mul_div_unit_16
  import mycpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  md_op_t           op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             flush_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_lo_out,
  output logic [WIDTH-1:0] result_hi_out,
  output logic             div0_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Two's-complement negate when requested; used for magnitudes and sign fix.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_t          r_state;
  md_op_t             r_op;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_div0;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_div0_out;

  // Operand conditioning at accept time.
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;
  logic                    w_b_zero;

  assign w_a_s    = a_in;
  assign w_b_s    = b_in;
  assign w_a_neg  = op_in[0] && (w_a_s < 0);
  assign w_b_neg  = op_in[0] && (w_b_s < 0);
  assign w_a_mag  = apply_sign(a_in, w_a_neg);
  assign w_b_mag  = apply_sign(b_in, w_b_neg);
  assign w_b_zero = op_in[1] && (b_in == '0);

  // Shared adder: hi + multiplicand for MUL, trial subtract of divisor for DIV.
  // For DIV the top carry is set exactly when the shifted remainder >= divisor.
  logic             w_is_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_add_x;
  logic [WIDTH:0]   w_add_y;
  logic [WIDTH+1:0] w_sum;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_is_div = r_op[1];
  assign w_shift  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_add_x  = w_is_div ? w_shift : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_add_y  = w_is_div ? ~{1'b0, r_opb} : {1'b0, r_opb};
  assign w_sum    = {1'b0, w_add_x} + {1'b0, w_add_y} + (WIDTH+2)'(w_is_div);
  assign w_ge     = w_sum[WIDTH+1];
  assign w_rem    = w_ge ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];

  // One iteration: right shift with add-carry for MUL, left shift with quotient bit for DIV.
  always_comb begin
    w_acc_next = r_acc;
    if (w_is_div) begin
      w_acc_next = {w_rem, r_acc[WIDTH-2:0], w_ge};
    end else if (r_acc[0]) begin
      w_acc_next = {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
    end else begin
      w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  // Final sign rules: product negated on sign mismatch; quotient by sign(a)^sign(b), remainder by sign(a).
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = apply_sign_wide(r_acc, r_neg_a ^ r_neg_b);
  assign w_quo_fix  = apply_sign(r_acc[WIDTH-1:0], r_neg_a ^ r_neg_b);
  assign w_rem_fix  = apply_sign(r_acc[2*WIDTH-1:WIDTH], r_neg_a);

  // Control FSM with datapath and registered results; flush aborts without touching results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MD_IDLE;
      r_op       <= MD_MUL_U;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div0     <= 1'b0;
      r_cnt      <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_div0_out <= 1'b0;
    end else if (flush_in) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE, MD_DONE: begin
          if (start_in) begin
            r_op    <= op_in;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_div0  <= w_b_zero;
            r_cnt   <= '0;
            if (w_b_zero) begin
              r_acc   <= {{WIDTH{1'b0}}, a_in};
              r_state <= MD_FIX;
            end else if (op_in[1]) begin
              r_opb   <= w_b_mag;
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
              r_state <= MD_CALC;
            end else begin
              r_opb   <= w_a_mag;
              r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
              r_state <= MD_CALC;
            end
          end else begin
            r_state <= MD_IDLE;
          end
        end
        MD_CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == LAST) begin
            r_state <= MD_FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MD_FIX: begin
          if (r_div0) begin
            r_lo <= '1;
            r_hi <= r_acc[WIDTH-1:0];
          end else if (r_op[1]) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
          r_div0_out <= r_div0;
          r_state    <= MD_DONE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign busy_out      = (r_state == MD_CALC) || (r_state == MD_FIX);
  assign done_out      = (r_state == MD_DONE);
  assign result_lo_out = r_lo;
  assign result_hi_out = r_hi;
  assign div0_out      = r_div0_out;

endmodule

// File: tb/tb_mul_div_unit_16.sv
// Directed bench for mul_div_unit_16 with hand-computed expected values.
module tb_mul_div_unit_16;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  md_op_t      op_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        flush_in;
  logic        busy_out;
  logic        done_out;
  logic [15:0] result_lo_out;
  logic [15:0] result_hi_out;
  logic        div0_out;

  int n_checks;
  int n_fail;

  mul_div_unit_16 #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .op_in         (op_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .flush_in      (flush_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .result_lo_out (result_lo_out),
    .result_hi_out (result_hi_out),
    .div0_out      (div0_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an op and wait (bounded) for done; lat = edges after T0 until done is seen.
  task automatic run_op(input md_op_t op, input logic [15:0] a, input logic [15:0] b, output int lat);
    op_in    = op;
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    lat      = 0;
    while (!done_out && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    int stray;
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({busy_out, done_out, div0_out, result_lo_out, result_hi_out} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_init: got busy=%b done=%b div0=%b lo=%h hi=%h, want all zero",
               busy_out, done_out, div0_out, result_lo_out, result_hi_out);
    end
    rst_n = 1'b1;
    step();
    // Leave non-zero results and div0 set so the mid-operation reset has something to clear.
    run_op(MD_DIV_U, 16'h5555, 16'h0000, lat);
    n_checks++;
    if (div0_out !== 1'b1 || result_hi_out !== 16'h5555) begin
      n_fail++;
      $display("FAIL reset_preload: got div0=%b hi=%h, want 1 5555", div0_out, result_hi_out);
    end
    op_in    = MD_MUL_U;
    a_in     = 16'd3;
    b_in     = 16'd5;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || div0_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b div0=%b, want 0 0 0", busy_out, done_out, div0_out);
    end
    n_checks++;
    if (result_lo_out !== 16'h0000 || result_hi_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_results: got lo=%h hi=%h, want 0000 0000", result_lo_out, result_hi_out);
    end
    step();
    rst_n = 1'b1;
    stray = 0;
    repeat (25) begin
      step();
      if (done_out || busy_out) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d busy/done cycles after release, want 0", stray);
    end
  endtask

  task automatic test_mul_u();
    int busy_bad;
    op_in    = MD_MUL_U;
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    busy_bad = 0;
    for (int i = 1; i <= 17; i++) begin
      if (busy_out !== 1'b1 || done_out !== 1'b0) busy_bad++;
      step();
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL mul_u_busy: got %0d cycles with busy low or early done in T0..T17, want 0", busy_bad);
    end
    n_checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_u_done: got done=%b busy=%b after T17, want 1 0", done_out, busy_out);
    end
    n_checks++;
    if (result_lo_out !== 16'h0001 || result_hi_out !== 16'hFFFE || div0_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_u_result: got lo=%h hi=%h div0=%b, want 0001 fffe 0",
               result_lo_out, result_hi_out, div0_out);
    end
    step();
    n_checks++;
    if (done_out !== 1'b0 || result_lo_out !== 16'h0001 || result_hi_out !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL mul_u_hold: got done=%b lo=%h hi=%h, want 0 0001 fffe",
               done_out, result_lo_out, result_hi_out);
    end
  endtask

  task automatic test_signed();
    int lat;
    run_op(MD_MUL_S, 16'hFFFD, 16'h0007, lat);
    n_checks++;
    if (lat !== 17 || result_lo_out !== 16'hFFEB || result_hi_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL mul_s_neg3x7: got lat=%0d lo=%h hi=%h, want 17 ffeb ffff", lat, result_lo_out, result_hi_out);
    end
    run_op(MD_DIV_S, 16'hFFF9, 16'h0002, lat);
    n_checks++;
    if (lat !== 17 || result_lo_out !== 16'hFFFD || result_hi_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL div_s_neg7by2: got lat=%0d lo=%h hi=%h, want 17 fffd ffff", lat, result_lo_out, result_hi_out);
    end
    run_op(MD_DIV_S, 16'h0007, 16'hFFFE, lat);
    n_checks++;
    if (result_lo_out !== 16'hFFFD || result_hi_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL div_s_7byneg2: got lo=%h hi=%h, want fffd 0001", result_lo_out, result_hi_out);
    end
    run_op(MD_MUL_S, 16'h8000, 16'h8000, lat);
    n_checks++;
    if (result_lo_out !== 16'h0000 || result_hi_out !== 16'h4000) begin
      n_fail++;
      $display("FAIL mul_s_minsq: got lo=%h hi=%h, want 0000 4000", result_lo_out, result_hi_out);
    end
  endtask

  task automatic test_div0();
    int lat;
    run_op(MD_DIV_U, 16'h1234, 16'h0000, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL div0_latency: got %0d edges after T0, want 1", lat);
    end
    n_checks++;
    if (result_lo_out !== 16'hFFFF || result_hi_out !== 16'h1234 || div0_out !== 1'b1) begin
      n_fail++;
      $display("FAIL div0_result: got lo=%h hi=%h div0=%b, want ffff 1234 1",
               result_lo_out, result_hi_out, div0_out);
    end
    repeat (3) step();
    n_checks++;
    if (div0_out !== 1'b1 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_hold: got div0=%b done=%b, want 1 0", div0_out, done_out);
    end
    run_op(MD_MUL_U, 16'd2, 16'd3, lat);
    n_checks++;
    if (div0_out !== 1'b0 || result_lo_out !== 16'h0006 || result_hi_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL div0_clear: got div0=%b lo=%h hi=%h, want 0 0006 0000",
               div0_out, result_lo_out, result_hi_out);
    end
  endtask

  task automatic test_flush();
    int lat;
    op_in    = MD_DIV_U;
    a_in     = 16'd100;
    b_in     = 16'd7;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (4) step();
    flush_in = 1'b1;
    start_in = 1'b1;
    step();
    flush_in = 1'b0;
    start_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ctrl: got busy=%b done=%b, want 0 0", busy_out, done_out);
    end
    n_checks++;
    if (result_lo_out !== 16'h0006 || result_hi_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL flush_hold: got lo=%h hi=%h, want 0006 0000", result_lo_out, result_hi_out);
    end
    run_op(MD_DIV_U, 16'd100, 16'd7, lat);
    n_checks++;
    if (lat !== 17 || result_lo_out !== 16'h000E || result_hi_out !== 16'h0002) begin
      n_fail++;
      $display("FAIL flush_restart: got lat=%0d lo=%h hi=%h, want 17 000e 0002", lat, result_lo_out, result_hi_out);
    end
  endtask

  task automatic test_back_to_back();
    int early;
    int late;
    int lat2;
    logic [15:0] lo2;
    logic [15:0] hi2;
    op_in    = MD_DIV_S;
    a_in     = 16'h8000;
    b_in     = 16'hFFFF;
    start_in = 1'b1;
    step();
    early = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (done_out) early++;
    end
    step();
    n_checks++;
    if (done_out !== 1'b1 || early !== 0) begin
      n_fail++;
      $display("FAIL b2b_first_done: got done=%b early=%0d at T17, want 1 0", done_out, early);
    end
    n_checks++;
    if (result_lo_out !== 16'h8000 || result_hi_out !== 16'h0000 || div0_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_min_by_neg1: got lo=%h hi=%h div0=%b, want 8000 0000 0",
               result_lo_out, result_hi_out, div0_out);
    end
    op_in = MD_MUL_U;
    a_in  = 16'd5;
    b_in  = 16'd5;
    step();
    start_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b1 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b after DONE-cycle start, want 1 0", busy_out, done_out);
    end
    late = 0;
    lat2 = 0;
    lo2  = 16'hDEAD;
    hi2  = 16'hDEAD;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done_out) begin
        late++;
        if (lat2 == 0) begin
          lat2 = i;
          lo2  = result_lo_out;
          hi2  = result_hi_out;
        end
      end
    end
    n_checks++;
    if (early + 1 + late !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d done pulses, want 2", early + 1 + late);
    end
    n_checks++;
    if (lat2 !== 17 || lo2 !== 16'h0019 || hi2 !== 16'h0000) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h, want 17 0019 0000", lat2, lo2, hi2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_in = 1'b0;
    flush_in = 1'b0;
    op_in    = MD_MUL_U;
    a_in     = 16'h0000;
    b_in     = 16'h0000;
    test_reset();
    test_mul_u();
    test_signed();
    test_div0();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
